divisor_secuencial: RTL and testbench

//   Iterative restoring divider, the inverse of the MULTIPLICADOR array multiplier.

---
 rtl/divisor_secuencial.sv | 126 ++++++++++++
 tb/tb_divisor_secuencial.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/divisor_secuencial.sv
// Iterative restoring divider, one quotient bit per clock; `DIVISOR_SIGNED_EN selects two's-complement operands.
// Latency SIZE+1 cycles from accepted iStart to oDone (1 for divide-by-zero); iStart is ignored while oBusy.
module divisor_secuencial #(
  parameter int SIZE = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            iStart,
  input  logic [SIZE-1:0] iA,
  input  logic [SIZE-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [SIZE-1:0] oQ,
  output logic [SIZE-1:0] oR,
  output logic            oDivZero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int         CW   = $clog2(SIZE + 1);

  logic [1:0]      state;
  logic [SIZE-1:0] dvd;
  logic [SIZE-1:0] dvs;
  logic [SIZE-1:0] rem;
  logic [CW-1:0]   cnt;

  logic [SIZE:0]   trial;
  logic [SIZE:0]   diff;
  logic            ge;
  logic [SIZE-1:0] rem_nxt;
  logic [SIZE-1:0] q_nxt;
  logic [SIZE-1:0] a_mag;
  logic [SIZE-1:0] b_mag;
  logic [SIZE-1:0] q_fin;
  logic [SIZE-1:0] r_fin;

  // Trial subtract is one bit wider than the operands so it never overflows.
  always_comb begin
    trial   = {rem, dvd[SIZE-1]};
    diff    = trial - {1'b0, dvs};
    ge      = (trial >= {1'b0, dvs});
    rem_nxt = ge ? diff[SIZE-1:0] : trial[SIZE-1:0];
    q_nxt   = {dvd[SIZE-2:0], ge};
  end

`ifdef DIVISOR_SIGNED_EN
  logic neg_q;
  logic neg_r;

  always_comb begin
    a_mag = iA[SIZE-1] ? -iA : iA;
    b_mag = iB[SIZE-1] ? -iB : iB;
    q_fin = neg_q ? -q_nxt : q_nxt;
    r_fin = neg_r ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if ((state != CALC) && iStart) begin
      neg_q <= iA[SIZE-1] ^ iB[SIZE-1];
      neg_r <= iA[SIZE-1];
    end
  end
`else
  always_comb begin
    a_mag = iA;
    b_mag = iB;
    q_fin = q_nxt;
    r_fin = rem_nxt;
  end
`endif

  assign oBusy = (state == CALC);
  assign oDone = (state == DONE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      oQ       <= '0;
      oR       <= '0;
      oDivZero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            if (iB == '0) begin
              oQ       <= '1;
              oR       <= iA;
              oDivZero <= 1'b1;
              state    <= DONE;
            end else begin
              dvd      <= a_mag;
              dvs      <= b_mag;
              rem      <= '0;
              cnt      <= CW'(SIZE);
              oDivZero <= 1'b0;
              state    <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          dvd <= q_nxt;
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            oQ    <= q_fin;
            oR    <= r_fin;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Scoreboard bench for divisor_secuencial: stimulus pushes expected results, a negedge monitor pops on oDone.
module tb_divisor_secuencial;
  localparam int SIZE = 16;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic            iStart = 1'b0;
  logic [SIZE-1:0] iA = '0;
  logic [SIZE-1:0] iB = '0;
  logic            oBusy;
  logic            oDone;
  logic [SIZE-1:0] oQ;
  logic [SIZE-1:0] oR;
  logic            oDivZero;

  divisor_secuencial #(.SIZE(SIZE)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iA(iA), .iB(iB),
    .oBusy(oBusy), .oDone(oDone), .oQ(oQ), .oR(oR), .oDivZero(oDivZero)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [SIZE-1:0] q;
    logic [SIZE-1:0] r;
    logic            dz;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every oDone must match the oldest outstanding expectation, including its cycle.
  always @(negedge Clock) begin
    if (Reset && oDone) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(oQ), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 64'(oQ), 64'(e.q));
        chk("remainder", 64'(oR), 64'(e.r));
        chk("divzero", 64'(oDivZero), 64'(e.dz));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called just after a negedge; the start is accepted at the following posedge.
  task automatic start_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic [SIZE-1:0] q, input logic [SIZE-1:0] r, input bit push);
    exp_t e;
    iStart = 1'b1;
    iA     = a;
    iB     = b;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    iA     = $urandom;
    iB     = $urandom;
    e.q    = q;
    e.r    = r;
    e.dz   = (b == '0);
    e.cyc  = cyc + ((b == '0) ? 0 : SIZE);
    if (push) sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge Clock);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!oDone && n < 60);
    if (!oDone) chk("wait_done_timeout", 64'(oDone), 64'd1);
  endtask

  initial begin
    #12;
    chk("reset_outputs", {oBusy, oDone, oDivZero, oQ, oR}, '0);
    @(negedge Clock);
    Reset = 1'b1;

    // 100/7 with busy window check, then back-to-back start from DONE.
    @(negedge Clock);
    start_op(16'd100, 16'd7, 16'd14, 16'd2, 1);
    @(negedge Clock);
    chk("busy_first", 64'(oBusy), 64'd1);
    repeat (14) @(negedge Clock);
    chk("busy_last", {oBusy, oDone}, 64'b10);
    wait_done();
    start_op(16'd200, 16'd9, 16'd22, 16'd2, 1);
    drain();

    // Extremes.
    @(negedge Clock);
`ifdef DIVISOR_SIGNED_EN
    start_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1);
    drain();
    @(negedge Clock);
    start_op(16'd3, 16'hFFFF, 16'hFFFD, 16'd0, 1);
    drain();
    @(negedge Clock);
    start_op(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1);
    drain();
    @(negedge Clock);
    start_op(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1);
    drain();
    @(negedge Clock);
    start_op(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1);
    drain();
`else
    start_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1);
    drain();
    @(negedge Clock);
    start_op(16'd3, 16'hFFFF, 16'd0, 16'd3, 1);
    drain();
    @(negedge Clock);
    start_op(16'hFFFF, 16'd256, 16'd255, 16'd255, 1);
    drain();
`endif

    // Divide by zero, result held in idle, then cleared by the next valid start.
    @(negedge Clock);
    start_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1);
    drain();
    repeat (3) @(negedge Clock);
    chk("held_after_dz", {oDivZero, oQ, oR}, {1'b1, 16'hFFFF, 16'd5});
    start_op(16'd12345, 16'd123, 16'd100, 16'd45, 1);
    @(negedge Clock);
    chk("dz_cleared", 64'(oDivZero), 64'd0);
    drain();

    // iStart while busy is ignored.
    @(negedge Clock);
    start_op(16'd1000, 16'd10, 16'd100, 16'd0, 1);
    repeat (4) @(negedge Clock);
    iStart = 1'b1;
    iA     = 16'd9;
    iB     = 16'd3;
    @(negedge Clock);
    iStart = 1'b0;
    drain();
    repeat (20) @(negedge Clock);

    // Reset mid-calculation aborts with no oDone.
    start_op(16'd500, 16'd3, 16'd0, 16'd0, 0);
    repeat (7) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("abort_outputs", {oBusy, oDone, oDivZero, oQ, oR}, '0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (25) @(negedge Clock);
    start_op(16'd500, 16'd3, 16'd166, 16'd2, 1);
    drain();
    repeat (3) @(negedge Clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
